// File: rtl/frame_capture_controller.sv
// Captures exactly one sensor frame, aligned to a vsync boundary, and streams
// its bytes with sequential addresses to the downstream memory unit.
module frame_capture_controller #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int BPP        = 2,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_strobe,
  input  logic [7:0]            cam_data,
  output logic [7:0]            out_data,
  output logic                  out_enable,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error
);

  localparam int BCW = $clog2(WIDTH*BPP + 1);
  localparam int LCW = $clog2(HEIGHT + 1);
  localparam logic [BCW-1:0] LINE_BYTES = BCW'(WIDTH*BPP);
  localparam logic [LCW-1:0] LINES      = LCW'(HEIGHT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } state_t;

  state_t                  state;
  logic                    href_p0;
  logic                    vsync_p0;
  logic [BCW-1:0]          byte_cnt;
  logic [LCW-1:0]          line_cnt;
  logic [ADDR_WIDTH-1:0]   addr;

  logic                    line_end;
  logic                    vsync_rise;
  logic                    byte_qual;
  logic [LCW-1:0]          line_next;

  assign line_end   = href_p0 & ~cam_href;
  assign vsync_rise = ~vsync_p0 & cam_vsync;
  assign byte_qual  = cam_href & cam_strobe;
  assign line_next  = line_cnt + 1'b1;

  // Stage p0: edge-detect history plus FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      href_p0     <= 1'b0;
      vsync_p0    <= 1'b0;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      addr        <= '0;
      out_data    <= '0;
      out_enable  <= 1'b0;
      out_address <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      href_p0    <= cam_href;
      vsync_p0   <= cam_vsync;
      out_enable <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          line_cnt <= '0;
          addr     <= '0;
          if (start) begin
            error <= 1'b0;
            busy  <= 1'b1;
            state <= WAIT_VSYNC;
          end
        end
        WAIT_VSYNC: begin
          if (cam_vsync) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!cam_vsync) state <= CAPTURE;
        end
        CAPTURE: begin
          if (byte_qual) begin
            if (byte_cnt < LINE_BYTES) begin
              out_data    <= cam_data;
              out_enable  <= 1'b1;
              out_address <= addr;
              addr        <= addr + 1'b1;
              byte_cnt    <= byte_cnt + 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
          // A line end and an early vsync in the same cycle: the line is
          // counted first, so a frame completed by that line is not an error.
          if (line_end) begin
            if (byte_cnt != LINE_BYTES) error <= 1'b1;
            line_cnt <= line_next;
            byte_cnt <= '0;
            if (line_next == LINES) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else if (vsync_rise) begin
              error      <= 1'b1;
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end else if (vsync_rise) begin
            error      <= 1'b1;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_controller.sv
// Scoreboard bench for frame_capture_controller with a 4x3 frame of 2-byte pixels.
module tb_frame_capture_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       cam_vsync;
  logic       cam_href;
  logic       cam_strobe;
  logic [7:0] cam_data;
  logic [7:0] out_data;
  logic       out_enable;
  logic [4:0] out_address;
  logic       busy;
  logic       frame_done;
  logic       error;

  frame_capture_controller #(
    .WIDTH(4), .HEIGHT(3), .BPP(2), .ADDR_WIDTH(5)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_strobe(cam_strobe),
    .cam_data(cam_data), .out_data(out_data), .out_enable(out_enable),
    .out_address(out_address), .busy(busy), .frame_done(frame_done),
    .error(error)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          exp_addr = 0;
  logic [7:0]  dval = 8'h00;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the next expected {address, data}
  always @(negedge clock) begin
    if (frame_done === 1'b1) done_cnt++;
    if (out_enable === 1'b1) begin
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_address", out_address, mon_e[12:8]);
        check("out_data", out_data, mon_e[7:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    cyc(3);
    cam_vsync = 1'b0;
    cyc(2);
  endtask

  task automatic send_byte(input bit wr);
    cam_href   = 1'b1;
    cam_strobe = 1'b1;
    cam_data   = dval;
    if (wr) begin
      exp_q.push_back({exp_addr[4:0], dval});
      exp_addr++;
    end
    dval = dval + 8'd1;
    cyc(1);
    cam_strobe = 1'b0;
    cyc(1);
  endtask

  task automatic send_line(input int n, input bit wr);
    for (int i = 0; i < n; i++) send_byte(wr && (i < 8));
    cam_href = 1'b0;
    cyc(3);
  endtask

  task automatic end_checks(input string tag, input int exp_done, input logic exp_err);
    #1;
    check({tag, "_frame_done_count"}, done_cnt, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    cyc(1);
    done_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_strobe = 1'b0; cam_data = 8'h00;
    cyc(2);
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_enable", out_enable, 0);
    check("rst_out_address", out_address, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_error", error, 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Normal frame: data 0x00..0x17 at addresses 0..23
    exp_addr = 0; dval = 8'h00; done_cnt = 0;
    pulse_start();
    #1 check("t1_busy_after_start", busy, 1);
    cyc(1);
    vsync_pulse();
    repeat (3) send_line(8, 1);
    end_checks("t1", 1, 1'b0);

    // Start mid-frame: bytes before the vsync sequence are ignored
    exp_addr = 0; dval = 8'h40;
    pulse_start();
    send_line(6, 0);
    send_line(8, 0);
    vsync_pulse();
    dval = 8'h00;
    repeat (3) send_line(8, 1);
    end_checks("t2", 1, 1'b0);

    // Overlong middle line: two bytes dropped, no address gap
    exp_addr = 0; dval = 8'h00;
    pulse_start();
    vsync_pulse();
    send_line(8, 1);
    send_line(10, 1);
    send_line(8, 1);
    end_checks("t3", 1, 1'b1);

    // Early vsync after two lines
    exp_addr = 0; dval = 8'h20;
    pulse_start();
    #1 check("t4_error_cleared_by_start", error, 0);
    cyc(1);
    vsync_pulse();
    repeat (2) send_line(8, 1);
    cam_vsync = 1'b1;
    cyc(3);
    cam_vsync = 1'b0;
    end_checks("t4", 1, 1'b1);

    // Reset in the middle of line 2, then a clean frame
    exp_addr = 0; dval = 8'h60;
    pulse_start();
    vsync_pulse();
    send_line(8, 1);
    repeat (3) send_byte(1);
    reset = 1'b1;
    cyc(1);
    #1;
    check("t5_out_enable", out_enable, 0);
    check("t5_out_data", out_data, 0);
    check("t5_out_address", out_address, 0);
    check("t5_busy", busy, 0);
    check("t5_frame_done", frame_done, 0);
    check("t5_error", error, 0);
    cyc(1);
    reset = 1'b0;
    cam_href = 1'b0;
    cyc(2);
    check("t5_no_stray_writes", exp_q.size(), 0);
    exp_addr = 0; dval = 8'h80;
    pulse_start();
    vsync_pulse();
    repeat (3) send_line(8, 1);
    end_checks("t5", 1, 1'b0);

    // Start during capture is ignored
    exp_addr = 0; dval = 8'hA0;
    pulse_start();
    vsync_pulse();
    send_line(8, 1);
    pulse_start();
    send_line(8, 1);
    pulse_start();
    send_line(8, 1);
    cyc(4);
    end_checks("t6", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_capture_controller.md
# frame_capture_controller

Camera-side capture stage placed directly upstream of `memoryManagementUnit`. It waits for a frame boundary on the sensor's vsync/href timing, qualifies incoming sensor bytes with a pixel strobe, and forwards exactly one frame as a byte stream. The stream is `out_data` + `out_enable` + `out_address`, which drive the memory unit's `data`/`enable` inputs. It also reports frame completion and timing errors to the system controller.

## Interface
- `WIDTH`, 640, pixels per line
- `HEIGHT`, 480, lines per frame
- `BPP`, 2, bytes per pixel
- `ADDR_WIDTH`, 20, output address width; must satisfy 2^ADDR_WIDTH >= WIDTH*HEIGHT*BPP
- `clock`  input  1  system clock; all logic on rising edge; single clock domain
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  single-cycle capture request
- `cam_vsync`  input  1  sensor vsync; high = vertical blanking; pre-synchronised to `clock`
- `cam_href`  input  1  sensor line-valid; pre-synchronised
- `cam_strobe`  input  1  one-cycle pulse per sensor byte (pclk edge already detected upstream)
- `cam_data`  input  8  sensor byte, valid when `cam_strobe`=1
- `out_data`  output  8  byte to memory unit
- `out_enable`  output  1  write strobe, one cycle per byte
- `out_address`  output  ADDR_WIDTH  byte address of `out_data`
- `busy`  output  1  high in any state other than IDLE
- `frame_done`  output  1  one-cycle pulse at end of capture
- `error`  output  1  sticky timing error; cleared on next accepted `start` or reset

## Operation
- FSM states: IDLE, WAIT_VSYNC, WAIT_FRAME, CAPTURE, DONE.
- **IDLE**
  - `start`=1 → WAIT_VSYNC.
  - Clears `error`, byte counter, line counter and address.
- **WAIT_VSYNC:** `cam_vsync`=1 → WAIT_FRAME. Guarantees capture never begins mid-frame.
- **WAIT_FRAME:** `cam_vsync`=0 → CAPTURE.
- **CAPTURE, byte path**
  - A qualifying byte is `cam_href`=1 && `cam_strobe`=1.
  - If line byte count < WIDTH*BPP: register `cam_data` into `out_data`, pulse `out_enable`, present the current address on `out_address`, then increment address and line byte count.
  - Bytes beyond WIDTH*BPP in a line are dropped and set `error`.
- **CAPTURE, line end**
  - Triggered on the `cam_href` falling edge (registered previous value 1, current 0).
  - If line byte count ≠ WIDTH*BPP → set `error`.
  - Increment line count and clear byte count.
  - If the new line count == HEIGHT → DONE.
- **CAPTURE, early vsync:** `cam_vsync` rising before HEIGHT lines → set `error`, → DONE.
- **DONE:** `frame_done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored.
- Address arithmetic:
  - Unsigned, starts at 0 each frame, +1 per written byte.
  - Maximum value WIDTH*HEIGHT*BPP−1; never wraps, because line and byte caps bound it.
- Simultaneous events in the same cycle:
  - A qualifying byte and the `cam_href` falling edge cannot coincide, since href=1 is required for a byte.
  - Early `cam_vsync` rise together with a line end: process the line end first (count, length check), then go to DONE. `error` is set only if the line count is still < HEIGHT.
- Reset in any state, including mid-line:
  - Next state IDLE, all counters 0, `error`=0.
  - No further `out_enable` pulses.

## Timing
- Reset values: `out_data`=0, `out_enable`=0, `out_address`=0, `busy`=0, `frame_done`=0, `error`=0.
- All outputs are registered.
- Write latency: `out_enable`/`out_data`/`out_address` assert 1 cycle after the qualifying `cam_strobe` cycle.
- `out_enable` never asserts on consecutive cycles unless `cam_strobe` does; there is no internal buffering.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `frame_done`.
- `frame_done` asserts the cycle after the transition condition into DONE.
- The last `out_enable` of a frame precedes or coincides with `frame_done`.

## Test plan
- WIDTH=4, HEIGHT=3, BPP=2; `start`, then vsync pulse, then 3 lines of 8 strobed bytes 0x00..0x17 → 24 `out_enable` pulses with addresses 0..23 and data 0x00..0x17; `frame_done` once; `error`=0.
- `start` asserted while vsync is low mid-frame with href active → no writes until a full vsync high→low sequence; then a normal capture from address 0.
- Line of 10 bytes (same params) → only 8 written for that line; `error`=1; next line starts at the next address with no gap; `frame_done` still after 3 lines.
- vsync rises after 2 lines → DONE with 16 writes (addresses 0..15), `error`=1, `frame_done` pulse.
- `reset` asserted mid-line 2 → next cycle all outputs at reset values, FSM IDLE; a new `start` captures a clean frame from address 0.
- `start` pulsed during CAPTURE → ignored: addresses continue monotonically and only one `frame_done` occurs.
